wb_reg_file: RTL
================

// Module: wb_reg_file
// PURPOSE
//  Architectural register file at the receiving end of the write-back path.
//  - Accepts the WB stage's selected result (ALU, memory or link PC) and commits it to the register array.
//  - Serves two combinational read ports to the ID stage, with optional same-cycle write-through bypass.
//  - Keeps a per-register pending-write counter. ID uses it to detect RAW hazards on results still in flight.
// PARAMETERS
//  DATA_W  32  register width
//  ADDR_W  5   register index width; the array holds 2**ADDR_W entries, and entry 0 is hardwired to zero
//  BYPASS  1   1 = a WB write is visible on the read ports in the same cycle; 0 = visible from the next cycle
//  PEND_W  2   pending-counter width per register; the maximum number of in-flight writes is 2**PEND_W-1
// PORTS
//  clk         in   1       rising-edge clock
//  rst         in   1       asynchronous, active-low reset (0 = reset)
//  wb_we       in   1       write-back enable (RegWrite of the instruction in WB)
//  wb_addr     in   ADDR_W  write-back destination register
//  wb_data     in   DATA_W  write-back data (output of the WB result mux)
//  iss_valid   in   1       an instruction that will write a register leaves ID this cycle
//  iss_addr    in   ADDR_W  destination register of that instruction
//  rd_addr_a   in   ADDR_W  read port A index (rs)
//  rd_data_a   out  DATA_W  read port A data
//  rd_busy_a   out  1       read port A register still has an uncommitted write pending
//  rd_addr_b   in   ADDR_W  read port B index (rt)
//  rd_data_b   out  DATA_W  read port B data
//  rd_busy_b   out  1       read port B register still has an uncommitted write pending
//  dbg_addr    in   ADDR_W  debug/testbench read index
//  dbg_data    out  DATA_W  debug read data (no bypass)
//  pend_err    out  1       sticky flag: pending-counter overflow or underflow
// BEHAVIOUR
//  Reset (rst=0, async):
//   - all registers = 0, all pending counters = 0, pend_err = 0.
//   - Consequently every rd_data/dbg_data = 0 and every rd_busy = 0 while rst=0.
//  Write:
//   - On posedge clk with wb_we=1 and wb_addr!=0: reg[wb_addr] <= wb_data.
//   - Writes to index 0 are discarded; reads of index 0 always return 0 and busy=0.
//  Read (combinational, zero latency):
//   - rd_data_x = reg[rd_addr_x].
//   - If BYPASS=1 and wb_we=1 and wb_addr==rd_addr_x!=0, then rd_data_x = wb_data.
//   - dbg_data never bypasses.
//  Pending counters pend[i], one per register, updated on posedge clk:
//   - Increment when iss_valid=1 and iss_addr==i.
//   - Decrement when wb_we=1 and wb_addr==i.
//   - Both events on the same i in one cycle: unchanged.
//   - Index 0 is never tracked and stays 0.
//   - Overflow (increment with pend==max and no matching decrement): counter holds at max, pend_err <= 1.
//   - Underflow (decrement with pend==0 and no matching increment): counter holds at 0, pend_err <= 1.
//   - pend_err is cleared only by reset.
//  Busy:
//   - rd_busy_x = (pend[rd_addr_x] - d) != 0, where d=1 if BYPASS=1 and wb_we=1 and wb_addr==rd_addr_x, else d=0.
//   - So the last outstanding write, when it is in WB, does not stall the reader if bypass is on.
//  Read ports A and B may address the same register; both return identical data and busy.
//  Reset asserted mid-operation clears all state immediately; the cycle after release behaves as post-reset.
// TESTING
//  1. Reset, release, read any index on A/B/dbg -> data=0, busy=0, pend_err=0.
//  2. wb_we=1, addr=5, data=0xDEADBEEF with rd_addr_a=5, BYPASS=1 -> rd_data_a=0xDEADBEEF in the same cycle; dbg_data(5) updates next cycle.
//  3. wb_we=1, addr=0, data=0x1234 -> reg 0 reads 0 on A, B and dbg; pend[0] stays 0.
//  4. Issue to r8 for three cycles -> rd_busy_a(8)=1.
//     - Three WB writes to r8 with values 1, 2, 3 -> busy drops while the third write is in WB (BYPASS=1).
//     - Final value reads 3.
//  5. Issue and WB to r9 in the same cycle with pend[9]=1 -> pend stays 1, busy=1. Fourth issue to r9 at pend=3 -> pend_err=1, counter holds at 3.
//  6. WB write to r10 with pend=0 -> data still written, pend_err=1.
//     - Assert rst mid-sequence -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/wb_reg_file_if.sv
// wb_reg_file_if
//   Groups the write-back, issue, read and debug signals of the architectural
//   register file into one bundle.
//   master : pipeline side (WB stage, ID stage, debug/testbench)
//   slave  : register file side
//   Signals:
//     wb_we/wb_addr/wb_data       write-back commit
//     iss_valid/iss_addr          destination of an instruction leaving ID
//     rd_addr_x/rd_data_x/rd_busy_x  read ports A and B with hazard flag
//     dbg_addr/dbg_data           non-bypassed debug read
//     pend_err                    sticky pending-counter error
interface wb_reg_file_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              wb_we;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              iss_valid;
  logic [ADDR_W-1:0] iss_addr;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [DATA_W-1:0] rd_data_a;
  logic              rd_busy_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_b;
  logic              rd_busy_b;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic              pend_err;

  modport master (
    output wb_we, wb_addr, wb_data, iss_valid, iss_addr,
           rd_addr_a, rd_addr_b, dbg_addr,
    input  rd_data_a, rd_busy_a, rd_data_b, rd_busy_b, dbg_data, pend_err
  );

  modport slave (
    input  wb_we, wb_addr, wb_data, iss_valid, iss_addr,
           rd_addr_a, rd_addr_b, dbg_addr,
    output rd_data_a, rd_busy_a, rd_data_b, rd_busy_b, dbg_data, pend_err
  );
endinterface

// File: rtl/wb_reg_file.sv
// wb_reg_file
//   Architectural register file fed by the write-back stage. Commits WB
//   results, serves two combinational read ports (optionally bypassing the
//   write in flight) and tracks per-register pending writes so ID can detect
//   RAW hazards.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-low reset (0 = reset)
//     bus  wb_reg_file_if slave modport (write-back, issue, read, debug, error)
module wb_reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1,
  parameter int PEND_W = 2
) (
  input  logic         clk,
  input  logic         rst,
  wb_reg_file_if.slave bus
);

  localparam int NREG = 2 ** ADDR_W;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [DATA_W-1:0] r_regs [NREG];
  logic [PEND_W-1:0] r_pend [NREG];
  logic              r_pendErr;

  logic [NREG-1:0]   w_inc;
  logic [NREG-1:0]   w_dec;
  logic [DATA_W-1:0] w_dataA;
  logic [DATA_W-1:0] w_dataB;
  logic              w_busyA;
  logic              w_busyB;

  // One-hot increment/decrement requests per register for this cycle.
  always_comb begin
    w_inc = '0;
    w_dec = '0;
    if (bus.iss_valid) w_inc[bus.iss_addr] = 1'b1;
    if (bus.wb_we)     w_dec[bus.wb_addr]  = 1'b1;
  end

  // Register array and pending counters. Entry 0 is never written or tracked.
  // Saturating counters: an overflow or underflow holds the value and sets
  // the sticky error flag instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
        r_pend[i] <= '0;
      end
      r_pendErr <= 1'b0;
    end else begin
      if (bus.wb_we && (bus.wb_addr != '0)) r_regs[bus.wb_addr] <= bus.wb_data;
      for (int i = 1; i < NREG; i++) begin
        if (w_inc[i] && !w_dec[i]) begin
          if (r_pend[i] == PEND_MAX) r_pendErr <= 1'b1;
          else                       r_pend[i] <= r_pend[i] + 1'b1;
        end else if (!w_inc[i] && w_dec[i]) begin
          if (r_pend[i] == '0) r_pendErr <= 1'b1;
          else                 r_pend[i] <= r_pend[i] - 1'b1;
        end
      end
    end
  end

  // True when the write currently in WB targets addr and bypass is enabled.
  function automatic logic hitsWb(input logic [ADDR_W-1:0] addr);
    return (BYPASS != 0) && bus.wb_we && (bus.wb_addr == addr);
  endfunction

  function automatic logic [DATA_W-1:0] readData(input logic [ADDR_W-1:0] addr);
    if (addr == '0)  return '0;
    if (hitsWb(addr)) return bus.wb_data;
    return r_regs[addr];
  endfunction

  // A write that is already in WB is not counted as outstanding when it
  // bypasses, so the last in-flight write does not stall the reader.
  function automatic logic readBusy(input logic [ADDR_W-1:0] addr);
    logic [PEND_W-1:0] d;
    d    = '0;
    d[0] = hitsWb(addr);
    return (addr != '0) && ((r_pend[addr] - d) != '0);
  endfunction

  // Combinational read ports.
  always_comb begin
    w_dataA = readData(bus.rd_addr_a);
    w_dataB = readData(bus.rd_addr_b);
    w_busyA = readBusy(bus.rd_addr_a);
    w_busyB = readBusy(bus.rd_addr_b);
  end

  // Reset gating keeps the bypass path from leaking WB data while in reset.
  assign bus.rd_data_a = rst ? w_dataA : '0;
  assign bus.rd_data_b = rst ? w_dataB : '0;
  assign bus.rd_busy_a = rst & w_busyA;
  assign bus.rd_busy_b = rst & w_busyB;
  assign bus.dbg_data  = r_regs[bus.dbg_addr];
  assign bus.pend_err  = r_pendErr;

endmodule
